// File: rtl/len_counter_if.sv
// Control/status bundle between a voice controller and its len_counter.
// Parameter: WIDTH - counter/limit/load width in bits.
// Signals:
//   clr      controller -> counter  sync clear to the counter's reset value
//   load     controller -> counter  sync load of load_val
//   load_val controller -> counter  value taken on load
//   en       controller -> counter  count enable
//   limit    controller -> counter  terminal value
//   count    counter -> controller  current count (registered)
//   tc       counter -> controller  count == limit (combinational)
//   done     counter -> controller  1-cycle pulse, limit reached on previous edge
interface len_counter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             done;

    // Voice controller side.
    modport master (
        output clr,
        output load,
        output load_val,
        output en,
        output limit,
        input  count,
        input  tc,
        input  done
    );

    // Counter side.
    modport slave (
        input  clr,
        input  load,
        input  load_val,
        input  en,
        input  limit,
        output count,
        output tc,
        output done
    );
endinterface

// File: rtl/len_counter.sv
// Note-length counter for one voice channel of the tone controller.
// Counts enabled clock cycles and flags when the count reaches a programmable limit.
// Parameters:
//   WIDTH    counter/limit/load width in bits
//   RST_VAL  value loaded into count by reset and by clr
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous reset, active low
//   bus      len_counter_if slave: clr, load, load_val, en, limit in;
//            count, tc, done out
// Build option:
//   LEN_COUNTER_SAT_EN  defined: count holds at limit once reached (one-shot);
//                       undefined (default): count wraps to 0 after limit.
module len_counter #(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    len_counter_if.slave bus
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             done_q;
    logic             done_d;
    logic [WIDTH-1:0] count_inc_c;
    logic             at_limit_c;

    assign count_inc_c = count_q + WIDTH'(1);
    assign at_limit_c  = (count_q == bus.limit);

    // Next state: clr > load > en > hold; done only ever set by an increment onto limit.
    always_comb begin
        count_d = count_q;
        done_d  = 1'b0;
        if (bus.clr) begin
            count_d = RST_VAL;
        end else if (bus.load) begin
            count_d = bus.load_val;
        end else if (bus.en) begin
            if (!at_limit_c) begin
                count_d = count_inc_c;
                done_d  = (count_inc_c == bus.limit);
            end else begin
`ifdef LEN_COUNTER_SAT_EN
                count_d = count_q;
`else
                count_d = '0;
`endif
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= RST_VAL;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = at_limit_c;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_len_counter.sv
module tb_len_counter;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned MODV  = 256;
    localparam logic [7:0]  RSTV  = 8'h00;

    logic clk;
    logic reset;

    len_counter_if #(.WIDTH(WIDTH)) bus ();

    len_counter #(.WIDTH(WIDTH), .RST_VAL(RSTV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state kept as plain integers.
    int m_cnt  = 0;
    int m_done = 0;

    typedef struct {
        logic       clr;
        logic       load;
        logic [7:0] lv;
        logic       en;
        logic [7:0] lim;
        logic [7:0] ec;
        logic       ed;
        logic       et;
    } vec_t;

    vec_t vecs[$];

    function automatic void addv(input logic c, input logic l, input logic [7:0] lv,
                                 input logic e, input logic [7:0] lim,
                                 input logic [7:0] ec, input logic ed, input logic et);
        vec_t v;
        v.clr = c; v.load = l; v.lv = lv; v.en = e; v.lim = lim;
        v.ec = ec; v.ed = ed; v.et = et;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rules: priority clr > load > en; terminal value wraps or holds.
    task automatic model_edge();
        int c, l, lv, e, lim;
        c = int'(bus.clr); l = int'(bus.load); lv = int'(bus.load_val);
        e = int'(bus.en); lim = int'(bus.limit);
        m_done = 0;
        if (c != 0)        m_cnt = int'(RSTV);
        else if (l != 0)   m_cnt = lv;
        else if (e != 0) begin
            if (m_cnt == lim) begin
`ifdef LEN_COUNTER_SAT_EN
                m_cnt = lim;
`else
                m_cnt = 0;
`endif
            end else begin
                m_cnt  = (m_cnt + 1) % MODV;
                m_done = (m_cnt == lim) ? 1 : 0;
            end
        end
    endtask

    task automatic drive(input logic c, input logic l, input logic [7:0] lv,
                         input logic e, input logic [7:0] lim);
        bus.clr = c; bus.load = l; bus.load_val = lv; bus.en = e; bus.limit = lim;
    endtask

    // One clock: model and DUT both advance; sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".count"}, int'(bus.count), m_cnt);
        chk({tag, ".done"}, int'(bus.done), m_done);
        chk({tag, ".tc"}, int'(bus.tc), (m_cnt == int'(bus.limit)) ? 1 : 0);
    endtask

    task automatic async_reset_pulse();
        #3;
        reset = 1'b0;
        #1;
        chk("async.count", int'(bus.count), int'(RSTV));
        chk("async.done", int'(bus.done), 0);
        m_cnt = int'(RSTV); m_done = 0;
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int edges;
        bit seen;
        logic [7:0] lim_r;

        reset = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        #3;
        chk("reset.count", int'(bus.count), int'(RSTV));
        chk("reset.done", int'(bus.done), 0);
        chk("reset.tc", int'(bus.tc), 1);
        #9;
        reset = 1'b1;

        // Limit 5 from 0.
        addv(1, 0, 8'h00, 0, 8'h05, 8'h00, 0, 0);
        addv(0, 0, 8'h00, 1, 8'h05, 8'h01, 0, 0);
        addv(0, 0, 8'h00, 1, 8'h05, 8'h02, 0, 0);
        addv(0, 0, 8'h00, 1, 8'h05, 8'h03, 0, 0);
        addv(0, 0, 8'h00, 1, 8'h05, 8'h04, 0, 0);
        addv(0, 0, 8'h00, 1, 8'h05, 8'h05, 1, 1);
`ifdef LEN_COUNTER_SAT_EN
        addv(0, 0, 8'h00, 1, 8'h05, 8'h05, 0, 1);
`else
        addv(0, 0, 8'h00, 1, 8'h05, 8'h00, 0, 0);
`endif
        // Load near full range.
        addv(0, 1, 8'hFD, 0, 8'hFF, 8'hFD, 0, 0);
        addv(0, 0, 8'h00, 1, 8'hFF, 8'hFE, 0, 0);
        addv(0, 0, 8'h00, 1, 8'hFF, 8'hFF, 1, 1);
`ifdef LEN_COUNTER_SAT_EN
        addv(0, 0, 8'h00, 1, 8'hFF, 8'hFF, 0, 1);
`else
        addv(0, 0, 8'h00, 1, 8'hFF, 8'h00, 0, 0);
`endif
        // clr beats load and en.
        addv(0, 1, 8'h20, 0, 8'hFF, 8'h20, 0, 0);
        addv(1, 1, 8'h55, 1, 8'hFF, 8'h00, 0, 0);
        // en toggling.
        addv(0, 0, 8'h00, 1, 8'hFF, 8'h01, 0, 0);
        addv(0, 0, 8'h00, 0, 8'hFF, 8'h01, 0, 0);
        addv(0, 0, 8'h00, 1, 8'hFF, 8'h02, 0, 0);
        addv(0, 0, 8'h00, 0, 8'hFF, 8'h02, 0, 0);
        // load beats en.
        addv(0, 1, 8'h40, 1, 8'hFF, 8'h40, 0, 0);
        // limit == RST_VAL.
        addv(1, 0, 8'h00, 0, 8'h00, 8'h00, 0, 1);
        addv(0, 0, 8'h00, 1, 8'h00, 8'h00, 0, 1);
        // load_val above limit runs through wrap.
        addv(0, 1, 8'hFE, 0, 8'h02, 8'hFE, 0, 0);
        addv(0, 0, 8'h00, 1, 8'h02, 8'hFF, 0, 0);
        addv(0, 0, 8'h00, 1, 8'h02, 8'h00, 0, 0);
        addv(0, 0, 8'h00, 1, 8'h02, 8'h01, 0, 0);
        addv(0, 0, 8'h00, 1, 8'h02, 8'h02, 1, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].clr, vecs[i].load, vecs[i].lv, vecs[i].en, vecs[i].lim);
            tick();
            chk($sformatf("vec%0d.count", i), int'(bus.count), int'(vecs[i].ec));
            chk($sformatf("vec%0d.done", i), int'(bus.done), int'(vecs[i].ed));
            chk($sformatf("vec%0d.tc", i), int'(bus.tc), int'(vecs[i].et));
        end

        // Async reset mid-count at 0x37 while done is high.
        drive(1'b0, 1'b1, 8'h36, 1'b0, 8'h37);
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b1, 8'h37);
        tick();
        chk("pre_async.count", int'(bus.count), 8'h37);
        chk("pre_async.done", int'(bus.done), 1);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h37);
        async_reset_pulse();
        tick();
        chk_model("post_async");

        // Period check: limit 5 from 0 over 12 enabled edges.
        drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h05);
        tick();
        edges = 0;
        for (int k = 0; k < 12; k++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b1, 8'h05);
            tick();
            chk_model($sformatf("period%0d", k));
            if (bus.done) edges++;
        end
`ifdef LEN_COUNTER_SAT_EN
        chk("period.done_pulses", edges, 1);
`else
        chk("period.done_pulses", edges, 2);
`endif

        // Limit dropped below the current count: tc only after wrapping.
        drive(1'b0, 1'b1, 8'h10, 1'b0, 8'hFF);
        tick();
        drive(1'b0, 1'b0, 8'h00, 1'b1, 8'h05);
        #1;
        chk("lowlim.tc_now", int'(bus.tc), 0);
        edges = 0;
        seen  = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            tick();
            edges++;
            if (bus.tc) seen = 1'b1;
        end
        chk("lowlim.seen", int'(seen), 1);
        chk("lowlim.edges", edges, (MODV - 16) + 5);
        chk_model("lowlim.end");

        // Randomized traffic against the reference.
        lim_r = 8'h07;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 99) < 3) lim_r = 8'($urandom_range(0, 255));
            else if ($urandom_range(0, 99) < 2) lim_r = 8'($urandom_range(0, 3));
            drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 23) == 0),
                  8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0), lim_r);
            tick();
            chk_model("rand");
            if (k == 1500) begin
                async_reset_pulse();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
